// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: multi-cycle mult/div with the HI/LO registers.
// Busy is registered; Start is a combinational accept strobe toward the hazard unit.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDU_Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_Out
);

  // state | meaning
  // IDLE  | nothing in flight; accepts mult/div and mthi/mtlo
  // RUN   | operation in flight; counter holds the cycles remaining
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [3:0]    op_q, op_n;
  logic [31:0]   a_q, a_n, b_q, b_n;
  logic [31:0]   hi_q, hi_n, lo_q, lo_n;

  logic [63:0]   prod_s, prod_u;
  logic [31:0]   b_safe, quo_s, rem_s, quo_u, rem_u;
  logic          div_zero, div_ovf;

  // Results are computed from the latched operands and only committed on the final cycle.
  always_comb begin
    div_zero = (b_q == 32'd0);
    div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    b_safe   = div_zero ? 32'd1 : b_q;
    prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    quo_u    = a_q / b_safe;
    rem_u    = a_q % b_safe;
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end else begin
      quo_s = $signed(a_q) / $signed(b_safe);
      rem_s = $signed(a_q) % $signed(b_safe);
    end
  end

  always_comb begin
    Busy  = (state_q == RUN);
    Start = (MDU_Op >= OP_MULT) && (MDU_Op <= OP_DIVU) && (state_q == IDLE);
    HI    = hi_q;
    LO    = lo_q;
    case (MDU_Op)
      OP_MFHI: MDU_Out = hi_q;
      OP_MFLO: MDU_Out = lo_q;
      default: MDU_Out = 32'd0;
    endcase
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          op_n    = MDU_Op;
          a_n     = A;
          b_n     = B;
          cnt_n   = (MDU_Op == OP_MULT || MDU_Op == OP_MULTU) ? CW'(MULT_CYCLES)
                                                              : CW'(DIV_CYCLES);
          state_n = RUN;
        end else if (MDU_Op == OP_MTHI) begin
          hi_n = A;
        end else if (MDU_Op == OP_MTLO) begin
          lo_n = A;
        end
      end
      RUN: begin
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_n = IDLE;
          case (op_q)
            OP_MULT:  {hi_n, lo_n} = prod_s;
            OP_MULTU: {hi_n, lo_n} = prod_u;
            OP_DIV: if (!div_zero) begin
              hi_n = rem_s;
              lo_n = quo_s;
            end
            OP_DIVU: if (!div_zero) begin
              hi_n = rem_u;
              lo_n = quo_u;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      op_q    <= op_n;
      a_q     <= a_n;
      b_q     <= b_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboarded bench for mdu_unit: stimulus queues expected HI/LO per operation,
// a monitor compares them whenever Busy falls.
module tb_mdu_unit;

  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdu_op;
  logic [31:0] a, b;
  logic        start, busy;
  logic [31:0] hi, lo, mdu_out;

  int passed = 0;
  int total  = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];
  logic        busy_d = 1'b0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDU_Op(mdu_op), .A(a), .B(b),
    .Start(start), .Busy(busy), .HI(hi), .LO(lo), .MDU_Out(mdu_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents op in the current cycle, checks Start and N busy cycles, returns at the
  // start of the first idle cycle after checking Busy has dropped.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int n, input logic [63:0] res);
    mdu_op = op; a = x; b = y;
    exp_q.push_back(res);
    name_q.push_back(nm);
    @(negedge clk);
    chk({nm, "_start"}, start, 1);
    for (int i = 1; i <= n; i++) begin
      tick();
      mdu_op = NONE;
      @(negedge clk);
      chk({nm, "_busy"}, busy, 1);
    end
    tick();
    chk({nm, "_done"}, busy, 0);
  endtask

  always @(negedge clk) begin : monitor
    logic [63:0] r;
    string       n;
    if (busy_d && !busy) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_completion: hi %h lo %h, required no pending result", hi, lo);
      end else begin
        r = exp_q.pop_front();
        n = name_q.pop_front();
        chk({n, "_hi"}, hi, r[63:32]);
        chk({n, "_lo"}, lo, r[31:0]);
      end
    end
    busy_d = busy;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mdu_op = NONE; a = 32'd0; b = 32'd0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    chk("none_out", mdu_out, 32'd0);

    run_op("mult_neg", MULT, 32'hFFFF_FFFE, 32'd3, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, {32'hFFFF_FFFE, 32'h0000_0001});
    mdu_op = MFHI; #1;
    chk("mfhi_out", mdu_out, 32'hFFFF_FFFE);
    tick();
    mdu_op = MFLO; #1;
    chk("mflo_out", mdu_out, 32'h0000_0001);
    tick();
    mdu_op = NONE;

    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 10, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu_zero", DIVU, 32'd7, 32'd0, 10, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, {32'h0000_0000, 32'h8000_0000});
    run_op("div_negdiv", DIV, 32'd7, 32'hFFFF_FFFE, 10, {32'h0000_0001, 32'hFFFF_FFFD});
    run_op("divu_rem", DIVU, 32'd100, 32'd7, 10, {32'd2, 32'd14});
    run_op("mult_ext", MULT, 32'h7FFF_FFFF, 32'h8000_0000, 5, {32'hC000_0000, 32'h8000_0000});

    mdu_op = MTLO; a = 32'h1234_5678;
    tick();
    chk("mtlo_lo", lo, 32'h1234_5678);
    mdu_op = MTHI; a = 32'hCAFE_F00D;
    tick();
    chk("mthi_hi", hi, 32'hCAFE_F00D);

    // Busy-period interference: MFLO sees old LO, MTHI and a second MULT are ignored.
    mdu_op = MULT; a = 32'd2; b = 32'd3;
    exp_q.push_back({32'd0, 32'd6});
    name_q.push_back("mult_ignore");
    #1;
    chk("ign_start", start, 1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      case (c)
        1: mdu_op = MFLO;
        2: begin mdu_op = MTHI; a = 32'hDEAD_BEEF; end
        3: begin mdu_op = MULT; a = 32'd9; b = 32'd9; end
        default: mdu_op = NONE;
      endcase
      #1;
      chk("ign_busy", busy, 1);
      if (c == 1) chk("ign_mflo_old", mdu_out, 32'h1234_5678);
      if (c == 3) begin
        chk("ign_busy_start", start, 0);
        chk("ign_mthi_hi", hi, 32'hCAFE_F00D);
      end
    end
    tick();
    mdu_op = NONE;
    chk("ign_done", busy, 0);

    mdu_op = DIV; a = 32'd100; b = 32'd3;
    exp_q.push_back({32'd0, 32'd0});
    name_q.push_back("div_reset");
    #1;
    chk("rdiv_start", start, 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      mdu_op = NONE;
      #1;
      chk("rdiv_busy", busy, 1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rdiv_busy_clr", busy, 0);
    chk("rdiv_hi_clr", hi, 32'd0);
    chk("rdiv_lo_clr", lo, 32'd0);
    repeat (8) tick();
    chk("rdiv_no_write", lo, 32'd0);
    chk("rdiv_idle", busy, 0);

    run_op("b2b_first", MULT, 32'd5, 32'd7, 5, {32'd0, 32'd35});
    run_op("b2b_second", MULTU, 32'h0001_0000, 32'h0001_0000, 5, {32'd1, 32'd0});

    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
